// File: rtl/vx_writeback_arbiter_pkg.sv
// Shared widths and types for the writeback arbiter and its per-source FIFOs.
package vx_writeback_arbiter_pkg;

    localparam int unsigned VX_NT      = 4;
    localparam int unsigned VX_NW_BITS = 1;

    // Packed FIFO entry layout: {warp, tmask, wb, rd, data}
    function automatic int unsigned wb_entry_w(input int unsigned nt, input int unsigned nw_bits);
        return nw_bits + nt + 1 + 5 + nt * 32;
    endfunction

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ALU,
        SEL_MEM
    } wb_sel_e;

endpackage

// File: rtl/vx_writeback_arbiter_fifo.sv
// Small skid FIFO holding writeback entries for one result source.
module vx_wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             data,
    output logic [WIDTH-1:0]             head,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/vx_writeback_arbiter.sv
// Merges ALU and load results into one register-file write per cycle; memory
// has priority, bounded by an ALU anti-starvation counter.
module vx_writeback_arbiter
    import vx_writeback_arbiter_pkg::*;
#(
    parameter int unsigned NT           = VX_NT,
    parameter int unsigned NW_BITS      = VX_NW_BITS,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_alu_valid,
    output logic                in_alu_ready,
    input  logic [NW_BITS-1:0]  in_alu_warp,
    input  logic [NT-1:0]       in_alu_tmask,
    input  logic                in_alu_wb,
    input  logic [4:0]          in_alu_rd,
    input  logic [NT*32-1:0]    in_alu_data,
    input  logic                in_mem_valid,
    output logic                in_mem_ready,
    input  logic [NW_BITS-1:0]  in_mem_warp,
    input  logic [NT-1:0]       in_mem_tmask,
    input  logic                in_mem_wb,
    input  logic [4:0]          in_mem_rd,
    input  logic [NT*32-1:0]    in_mem_data,
    output logic [NW_BITS-1:0]  out_wb_warp,
    output logic [NT-1:0]       out_valid,
    output logic                out_write_register,
    output logic [4:0]          out_rd,
    output logic [NT*32-1:0]    out_write_data,
    output logic                out_busy
);

    localparam int unsigned EW = wb_entry_w(NT, NW_BITS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [EW-1:0] alu_head, mem_head, win_head;
    logic          alu_empty, mem_empty;
    logic [CW-1:0] alu_count, mem_count;
    logic [SW-1:0] starve_cnt;
    wb_sel_e       sel;

    logic [NW_BITS-1:0] h_warp;
    logic [NT-1:0]      h_tmask;
    logic               h_wb;
    logic [4:0]         h_rd;
    logic [NT*32-1:0]   h_data;

    // Ready depends only on the current count, so a full FIFO refuses even when it pops.
    assign in_alu_ready = reset && (alu_count < CW'(FIFO_DEPTH));
    assign in_mem_ready = reset && (mem_count < CW'(FIFO_DEPTH));

    vx_wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) alu_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_alu_valid && in_alu_ready),
        .pop   (sel == SEL_ALU),
        .data  ({in_alu_warp, in_alu_tmask, in_alu_wb, in_alu_rd, in_alu_data}),
        .head  (alu_head),
        .empty (alu_empty),
        .count (alu_count)
    );

    vx_wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) mem_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_mem_valid && in_mem_ready),
        .pop   (sel == SEL_MEM),
        .data  ({in_mem_warp, in_mem_tmask, in_mem_wb, in_mem_rd, in_mem_data}),
        .head  (mem_head),
        .empty (mem_empty),
        .count (mem_count)
    );

    always_comb begin
        sel = SEL_NONE;
        if (!alu_empty && !mem_empty)
            sel = (starve_cnt == SW'(STARVE_LIMIT)) ? SEL_ALU : SEL_MEM;
        else if (!mem_empty)
            sel = SEL_MEM;
        else if (!alu_empty)
            sel = SEL_ALU;
    end

    assign win_head = (sel == SEL_MEM) ? mem_head : alu_head;
    assign {h_warp, h_tmask, h_wb, h_rd, h_data} = win_head;

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt         <= '0;
            out_wb_warp        <= '0;
            out_valid          <= '0;
            out_write_register <= 1'b0;
            out_rd             <= '0;
            out_write_data     <= '0;
        end else begin
            // MEM winning with ALU waiting is the only case that grows the count.
            if (sel == SEL_MEM && !alu_empty) begin
                if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end

            if (sel != SEL_NONE) begin
                out_write_register <= h_wb && (h_rd != '0) && (h_tmask != '0);
                out_valid          <= h_tmask;
                out_rd             <= h_rd;
                out_wb_warp        <= h_warp;
                out_write_data     <= h_data;
            end else begin
                out_write_register <= 1'b0;
                out_valid          <= '0;
            end
        end
    end

    assign out_busy = !alu_empty || !mem_empty || out_write_register;

endmodule

// File: tb/tb_vx_writeback_arbiter.sv
// Randomized bench for vx_writeback_arbiter against a queue-based reference model.
module tb_vx_writeback_arbiter;

    localparam int LIMIT = 3;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [0:0]   warp;
        logic [3:0]   tmask;
        logic         wb;
        logic [4:0]   rd;
        logic [127:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    logic va, vm;
    ent_t ca, cm;

    logic         in_alu_ready, in_mem_ready;
    logic [0:0]   out_wb_warp;
    logic [3:0]   out_valid;
    logic         out_write_register;
    logic [4:0]   out_rd;
    logic [127:0] out_write_data;
    logic         out_busy;

    vx_writeback_arbiter #(.NT(4), .NW_BITS(1), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk                (clk),
        .reset              (rst_n),
        .in_alu_valid       (va),
        .in_alu_ready       (in_alu_ready),
        .in_alu_warp        (ca.warp),
        .in_alu_tmask       (ca.tmask),
        .in_alu_wb          (ca.wb),
        .in_alu_rd          (ca.rd),
        .in_alu_data        (ca.data),
        .in_mem_valid       (vm),
        .in_mem_ready       (in_mem_ready),
        .in_mem_warp        (cm.warp),
        .in_mem_tmask       (cm.tmask),
        .in_mem_wb          (cm.wb),
        .in_mem_rd          (cm.rd),
        .in_mem_data        (cm.data),
        .out_wb_warp        (out_wb_warp),
        .out_valid          (out_valid),
        .out_write_register (out_write_register),
        .out_rd             (out_rd),
        .out_write_data     (out_write_data),
        .out_busy           (out_busy)
    );

    always #5 clk = ~clk;

    logic [141:0] obs;
    assign obs = {out_write_register, out_valid, out_rd, out_wb_warp, out_write_data,
                  out_busy, in_alu_ready, in_mem_ready};

    // Reference model state
    ent_t         qa[$], qm[$];
    int           starve;
    logic         e_wr;
    logic [3:0]   e_valid;
    logic [4:0]   e_rd;
    logic [0:0]   e_warp;
    logic [127:0] e_data;
    bit           acc_a, acc_m;
    bit           force_src_warp;

    int n_vec  = 0;
    int n_fail = 0;

    function automatic logic [141:0] expv();
        logic busy, ra, rm;
        busy = (qa.size() != 0) || (qm.size() != 0) || e_wr;
        ra   = rst_n && (qa.size() < DEPTH);
        rm   = rst_n && (qm.size() < DEPTH);
        return {e_wr, e_valid, e_rd, e_warp, e_data, busy, ra, rm};
    endfunction

    function automatic ent_t rand_ent(input bit good);
        ent_t e;
        e.warp  = 1'($urandom);
        e.tmask = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
        e.wb    = ($urandom_range(0, 4) != 0);
        e.rd    = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        e.data  = {$urandom, $urandom, $urandom, $urandom};
        if (good) begin
            e.wb = 1'b1;
            if (e.rd == 5'd0) e.rd = 5'd7;
            if (e.tmask == 4'h0) e.tmask = 4'h9;
        end
        return e;
    endfunction

    // A pending (valid but not accepted) request keeps its data; otherwise draw a new one.
    task automatic next_inputs(input bit a_en, input bit m_en, input bit a_good, input bit m_good);
        if (!(va && !acc_a)) begin
            va = a_en;
            ca = rand_ent(a_good);
            if (force_src_warp) ca.warp = 1'b0;
        end
        if (!(vm && !acc_m)) begin
            vm = m_en;
            cm = rand_ent(m_good);
            if (force_src_warp) cm.warp = 1'b1;
        end
    endtask

    // Advance one clock and update the model from the spec's rules.
    task automatic cycle();
        bit pa, pm, both;
        int win;
        ent_t h;
        pa = va && rst_n && (qa.size() < DEPTH);
        pm = vm && rst_n && (qm.size() < DEPTH);
        @(posedge clk);
        if (!rst_n) begin
            qa.delete(); qm.delete();
            starve = 0;
            e_wr = 1'b0; e_valid = '0; e_rd = '0; e_warp = '0; e_data = '0;
            acc_a = 0; acc_m = 0;
        end else begin
            both = (qa.size() != 0) && (qm.size() != 0);
            if (both)                win = (starve == LIMIT) ? 1 : 2;
            else if (qm.size() != 0) win = 2;
            else if (qa.size() != 0) win = 1;
            else                     win = 0;
            if (both && win == 2)                starve = (starve < LIMIT) ? starve + 1 : LIMIT;
            else if (win == 1 || qa.size() == 0) starve = 0;
            if (win != 0) begin
                h = (win == 1) ? qa.pop_front() : qm.pop_front();
                e_wr    = h.wb && (h.rd != 0) && (h.tmask != 0);
                e_valid = h.tmask;
                e_rd    = h.rd;
                e_warp  = h.warp;
                e_data  = h.data;
            end else begin
                e_wr    = 1'b0;
                e_valid = '0;
            end
            if (pa) qa.push_back(ca);
            if (pm) qm.push_back(cm);
            acc_a = pa; acc_m = pm;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            va = 1'($urandom); vm = 1'($urandom);
            ca = rand_ent(0); cm = rand_ent(0);
            cycle();
            n_vec++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL reset_vec: got %h exp %h", obs, expv());
            end
            n_vec++;
            if ({out_write_register, out_valid, out_busy, in_alu_ready, in_mem_ready} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_zero: got %b exp 00000000",
                         {out_write_register, out_valid, out_busy, in_alu_ready, in_mem_ready});
            end
        end
        rst_n = 1'b1; va = 1'b0; vm = 1'b0;
        cycle();
        n_vec++;
        if ({in_alu_ready, in_mem_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL release_ready: got %b exp 11", {in_alu_ready, in_mem_ready});
        end
    endtask

    task automatic test_single_alu();
        ca.warp = 1'b0; ca.tmask = 4'hF; ca.wb = 1'b1; ca.rd = 5'd5;
        ca.data = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
        va = 1'b1;
        cycle();
        n_vec++;
        if (obs !== expv()) begin
            n_fail++;
            $display("FAIL single_accept: got %h exp %h", obs, expv());
        end
        va = 1'b0;
        cycle();
        n_vec++;
        if ({out_write_register, out_rd, out_valid, out_write_data} !==
            {1'b1, 5'd5, 4'hF, 32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}) begin
            n_fail++;
            $display("FAIL single_write: got %h exp %h",
                     {out_write_register, out_rd, out_valid, out_write_data},
                     {1'b1, 5'd5, 4'hF, 32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001});
        end
        cycle();
        n_vec++;
        if (out_write_register !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drop: got %b exp 0", out_write_register);
        end
    endtask

    task automatic test_filters();
        for (int i = 0; i < 3; i++) begin
            ca = rand_ent(1);
            if (i == 0) ca.rd = 5'd0;
            if (i == 1) ca.wb = 1'b0;
            if (i == 2) ca.tmask = 4'h0;
            va = 1'b1;
            cycle();
            n_vec++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL filter_vec%0d: got %h exp %h", i, obs, expv());
            end
        end
        va = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_vec++;
            if (obs !== expv() || out_write_register !== 1'b0) begin
                n_fail++;
                $display("FAIL filter_drain%0d: got %h exp %h", i, obs, expv());
            end
        end
        n_vec++;
        if (out_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL filter_busy: got %b exp 0", out_busy);
        end
    endtask

    // ALU results carry warp 0, MEM results warp 1, so out_wb_warp names the winner.
    task automatic test_contention();
        force_src_warp = 1;
        for (int k = 0; k < 12; k++) begin
            next_inputs(1, 1, 1, 1);
            cycle();
            n_vec++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL contend_vec%0d: got %h exp %h", k, obs, expv());
            end
            if (k >= 1) begin
                n_vec++;
                if (out_write_register !== 1'b1 || out_wb_warp !== (((k - 1) % 4 == 3) ? 1'b0 : 1'b1)) begin
                    n_fail++;
                    $display("FAIL contend_order%0d: got wr=%b src=%b exp wr=1 src=%b", k,
                             out_write_register, out_wb_warp, (((k - 1) % 4 == 3) ? 1'b0 : 1'b1));
                end
            end
        end
        force_src_warp = 0;
    endtask

    task automatic test_reset_mid();
        next_inputs(1, 1, 1, 1);
        cycle();
        rst_n = 1'b0;
        cycle();
        n_vec++;
        if (obs !== expv() || out_write_register !== 1'b0 || out_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_vec: got %h exp %h", obs, expv());
        end
        rst_n = 1'b1; va = 1'b0; vm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_vec++;
            if (obs !== expv() || out_write_register !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_idle%0d: got %h exp %h", i, obs, expv());
            end
        end
    endtask

    task automatic test_random_backpressure();
        for (int k = 0; k < 400; k++) begin
            next_inputs($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 0, 0);
            cycle();
            n_vec++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL random_vec%0d: got %h exp %h", k, obs, expv());
            end
        end
        va = 1'b0; vm = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            n_vec++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL random_drain%0d: got %h exp %h", k, obs, expv());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; va = 1'b0; vm = 1'b0;
        ca = '0; cm = '0;
        acc_a = 0; acc_m = 0; starve = 0; force_src_warp = 0;
        e_wr = 1'b0; e_valid = '0; e_rd = '0; e_warp = '0; e_data = '0;
        test_reset();
        test_single_alu();
        test_filters();
        test_contention();
        test_reset_mid();
        test_random_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
